// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core.
// Detects load-use and multiplier hazards for the instruction in ID, applies
// branch flushes, and tracks the multi-cycle multiplier until writeback.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rd_we_i,
  input  logic             id_is_load_i,
  input  logic             id_is_mul_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             issue_o,
  output logic             mul_busy_o,
  output logic             mul_wb_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {IDLE, BUSY} mul_st_e;

  mul_st_e    state_q;
  logic [3:0] cnt_q;
  logic [4:0] mul_rd_q;
  logic       busy_q, wb_q;

  logic       ex_valid_q, ex_load_q;
  logic [4:0] ex_rd_q;

  logic hit_ex, hit_mul, waw_mul;
  logic load_use, mul_haz, stall, flush;

  // Source-operand match against a producer; x0 never matches.
  assign hit_ex  = (ex_rd_q != 5'd0) &
                   ((id_uses_rs1_i & (id_rs1_i == ex_rd_q)) |
                    (id_uses_rs2_i & (id_rs2_i == ex_rd_q)));
  assign hit_mul = (mul_rd_q != 5'd0) &
                   ((id_uses_rs1_i & (id_rs1_i == mul_rd_q)) |
                    (id_uses_rs2_i & (id_rs2_i == mul_rd_q)));
  // Writing the multiplier's destination early would be overwritten by the
  // later writeback, so WAW is held too.
  assign waw_mul = id_rd_we_i & (id_rd_i != 5'd0) & (id_rd_i == mul_rd_q);

  assign load_use = id_valid_i & ex_valid_q & ex_load_q & hit_ex;
  assign mul_haz  = id_valid_i & busy_q & (id_is_mul_i | hit_mul | waw_mul);
  assign stall    = load_use | mul_haz;
  assign flush    = ex_branch_taken_i;

  // Flush takes priority: the stalled instruction is on the wrong path anyway.
  assign pc_stall_o     = stall & ~flush;
  assign if_id_stall_o  = stall & ~flush;
  assign if_id_flush_o  = flush;
  assign id_ex_bubble_o = stall | flush;
  assign issue_o        = id_valid_i & ~stall & ~flush;
  assign mul_busy_o     = busy_q;
  assign mul_wb_o       = wb_q;

  // Track what just entered EX so a dependent reader of a load can be held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_load_q  <= 1'b0;
    end else begin
      ex_valid_q <= issue_o;
      ex_rd_q    <= id_rd_i;
      ex_load_q  <= id_is_load_i & id_rd_we_i;
    end
  end

  // Multiplier occupancy FSM; busy/wb are registered alongside the state.
  // A flush does not touch it since the multiply is older than the branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mul_rd_q <= 5'd0;
      busy_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_q <= 1'b0;
          if (issue_o && id_is_mul_i) begin
            state_q  <= BUSY;
            cnt_q    <= 4'(MUL_LAT - 1);
            mul_rd_q <= id_rd_i;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            wb_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            wb_q  <= (cnt_q == 4'd1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wb_q    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles the front end was actually held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (pc_stall_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0 / unused-operand filtering,
// multiplier chain, WAW, flush priority, mid-multiply reset, counter saturation.
module tb_hazard_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, id_is_load, id_is_mul, br_taken;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue, mul_busy, mul_wb;
  logic [CW-1:0] stall_cnt;
  logic [6:0]    outs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_is_load_i(id_is_load),
    .id_is_mul_i(id_is_mul), .ex_branch_taken_i(br_taken),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_bubble_o(id_ex_bubble), .issue_o(issue), .mul_busy_o(mul_busy),
    .mul_wb_o(mul_wb), .stall_cnt_o(stall_cnt)
  );

  // {pc_stall, if_id_stall, if_id_flush, bubble, issue, busy, wb}
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue, mul_busy, mul_wb};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic we, input logic ld, input logic mul, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_is_mul = mul; br_taken = br;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check mid-cycle, then advance past the next rising edge.
  task automatic step(input string tag, input logic [6:0] eo, input int ec);
    #2;
    chk({tag, ".out"}, 32'(outs), 32'(eo));
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(ec));
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    tick();
    #2;
    chk("reset.out", 32'(outs), 32'd0);
    chk("reset.cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // load-use on rs1
    set(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); step("lu_lw",   7'b0000100, 0);
    set(1, 5, 7, 1, 1, 6, 1, 0, 0, 0); step("lu_stall", 7'b1101000, 0);
    step("lu_issue", 7'b0000100, 1);

    // x0 and unused operands never hazard
    set(1, 1, 0, 1, 0, 0, 1, 1, 0, 0); step("x0_lw",   7'b0000100, 1);
    set(1, 0, 0, 1, 1, 8, 1, 1, 0, 0); step("x0_rd",   7'b0000100, 1);
    set(1, 8, 8, 0, 0, 9, 1, 0, 0, 0); step("unused",  7'b0000100, 1);

    // load-use on rs2
    set(1, 1, 0, 1, 0, 10, 1, 1, 0, 0); step("lu2_lw",    7'b0000100, 1);
    set(1, 1, 10, 1, 1, 11, 1, 0, 0, 0); step("lu2_stall", 7'b1101000, 1);
    step("lu2_issue", 7'b0000100, 2);

    // mul x3 then dependent add x4,x3,x1
    set(1, 1, 2, 1, 1, 3, 1, 0, 1, 0); step("mul_iss", 7'b0000100, 2);
    set(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    step("dep_c1", 7'b1101010, 2);
    step("dep_c2", 7'b1101010, 3);
    step("dep_c3", 7'b1101010, 4);
    step("dep_wb", 7'b1101011, 5);
    step("dep_iss", 7'b0000100, 6);

    // second multiply held the same way
    set(1, 1, 2, 1, 1, 11, 1, 0, 1, 0); step("mulA", 7'b0000100, 6);
    set(1, 5, 6, 1, 1, 12, 1, 0, 1, 0);
    step("mulB_c1", 7'b1101010, 6);
    step("mulB_c2", 7'b1101010, 7);
    step("mulB_c3", 7'b1101010, 8);
    step("mulB_wb", 7'b1101011, 9);
    step("mulB_iss", 7'b0000100, 10);

    // independent add while busy on x12, then WAW on x12
    set(1, 1, 2, 1, 1, 9, 1, 0, 0, 0); step("indep", 7'b0000110, 10);
    set(1, 1, 0, 1, 0, 12, 1, 0, 0, 0); step("waw", 7'b1101010, 10);
    // flush wins over the WAW stall; multiply keeps running
    set(1, 1, 0, 1, 0, 12, 1, 0, 0, 1); step("flush_mul", 7'b0011010, 11);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("flush_wb", 7'b0000011, 11);
    step("idle", 7'b0000000, 11);

    // flush over load-use
    set(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); step("fl_lw", 7'b0000100, 11);
    set(1, 5, 7, 1, 1, 6, 1, 0, 0, 1); step("fl_lu", 7'b0011000, 11);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("fl_after", 7'b0000000, 11);

    // reset mid-multiply at cnt_q == 2
    set(1, 1, 2, 1, 1, 3, 1, 0, 1, 0); step("rm_iss", 7'b0000100, 11);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("rm_c1", 7'b0000010, 11);
    #2;
    chk("rm_c2.out", 32'(outs), 32'(7'b0000010));
    rst_n = 1'b0;
    #1;
    chk("rm_async.out", 32'(outs), 32'd0);
    chk("rm_async.cnt", 32'(stall_cnt), 32'd0);
    tick();
    #2;
    chk("rm_hold.out", 32'(outs), 32'd0);
    rst_n = 1'b1;
    tick();
    set(1, 1, 2, 1, 1, 3, 1, 0, 1, 0); step("rr_iss", 7'b0000100, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rr_c1", 7'b0000010, 0);
    step("rr_c2", 7'b0000010, 0);
    step("rr_c3", 7'b0000010, 0);
    step("rr_wb", 7'b0000011, 0);
    step("rr_idle", 7'b0000000, 0);

    // back-to-back multiplies: 4 stalls per 5 cycles; 319 cycles -> 255 stalls
    set(1, 1, 2, 1, 1, 3, 1, 0, 1, 0);
    repeat (319) tick();
    #2;
    chk("sat_255", 32'(stall_cnt), 32'd255);
    tick();
    repeat (4) tick();
    #2;
    chk("sat_hold", 32'(stall_cnt), 32'd255);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    #2;
    chk("final_idle", 32'(outs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
